// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter: two-master (CPU/host) arbiter for a single-ported data memory with host aging and lock
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   cpu_*                   CPU data port: req/we/addr/wdata in, gnt (comb), rvalid/rdata out
//   host_*                  host/loader port: req/we/lock/addr/wdata in, gnt (comb), rvalid/rdata out
//   mem_addr/wdata/we       muxed memory request; mem_rdata returns one cycle after the address
//   busy                    a grant is active or a read is in flight
// Optional build macro DMEM_ARB_STATS_EN adds stats_clr input and
//   cpu_grant_cnt/host_grant_cnt/conflict_cnt 16-bit wrapping counters.
module sc_dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       host_grant_cnt,
  output logic [15:0]       conflict_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, CPU_OWN, HOST_OWN, HOST_LOCKED} state_t;
  localparam logic [3:0] MW = MAX_WAIT[3:0];
  state_t state, state_d;
  logic [3:0] wait_cnt;
  logic rd_pend, rd_owner;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
  always_comb begin
    host_gnt = !reset && host_req && ((state == HOST_LOCKED) || (wait_cnt == MW) || !cpu_req);
    cpu_gnt  = !reset && cpu_req && !host_gnt;
    state_d  = cpu_gnt ? CPU_OWN : host_gnt ? (host_lock ? HOST_LOCKED : HOST_OWN) : IDLE;
  end
  assign mem_addr    = host_gnt ? host_addr : cpu_addr;
  assign mem_wdata   = host_gnt ? host_wdata : cpu_wdata;
  assign mem_we      = host_gnt ? host_we : (cpu_gnt & cpu_we);
  // a read still in flight when reset asserts is dropped without an rvalid
  assign cpu_rvalid  = rd_pend & ~rd_owner & ~reset;
  assign host_rvalid = rd_pend & rd_owner & ~reset;
  assign cpu_rdata   = reset ? '0 : cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign host_rdata  = reset ? '0 : host_rvalid ? mem_rdata : host_rdata_q;
  assign busy        = cpu_gnt | host_gnt | (rd_pend & ~reset);
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state        <= state_d;
      wait_cnt     <= (!host_req || host_gnt) ? 4'd0 : (wait_cnt == MW) ? wait_cnt : wait_cnt + 4'd1;
      rd_pend      <= (cpu_gnt & ~cpu_we) | (host_gnt & ~host_we);
      rd_owner     <= host_gnt;
      cpu_rdata_q  <= cpu_rvalid ? mem_rdata : cpu_rdata_q;
      host_rdata_q <= host_rvalid ? mem_rdata : host_rdata_q;
    end
  end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || stats_clr) begin
      cpu_grant_cnt  <= '0;
      host_grant_cnt <= '0;
      conflict_cnt   <= '0;
    end else begin
      cpu_grant_cnt  <= cpu_grant_cnt + {15'd0, cpu_gnt};
      host_grant_cnt <= host_grant_cnt + {15'd0, host_gnt};
      conflict_cnt   <= conflict_cnt + {15'd0, cpu_req & host_req};
    end
  end
`endif
endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// tb_sc_dmem_arbiter: directed self-checking bench for sc_dmem_arbiter with a small memory model
module tb_sc_dmem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
  logic cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_we, busy;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic pl_en = 0;
  logic [5:0] pl_idx = 0;
  logic [31:0] pl_data = 0;
  logic [31:0] mem [64];
  int errors = 0;
  int checks = 0;
`ifdef DMEM_ARB_STATS_EN
  logic stats_clr = 0;
  logic [15:0] cpu_grant_cnt, host_grant_cnt, conflict_cnt;
`endif

  sc_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .cpu_grant_cnt(cpu_grant_cnt),
    .host_grant_cnt(host_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic idle(input int n);
    cpu_req = 0; host_req = 0; host_lock = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    pl_en = 1; pl_idx = idx; pl_data = d;
    @(posedge clock); #1;
    pl_en = 0;
  endtask

  task automatic test_reset;
    reset = 1; cpu_req = 1; host_req = 1; cpu_we = 1; host_we = 1;
    cpu_addr = 32'h100; host_addr = 32'h104;
    repeat (2) begin
      @(posedge clock); #1;
      checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt got %b exp 0", cpu_gnt); end
      checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL rst_host_gnt got %b exp 0", host_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
      checks++; if ({cpu_rvalid, host_rvalid, busy} !== 3'b000) begin errors++; $display("FAIL rst_rvalid_busy got %b exp 000", {cpu_rvalid, host_rvalid, busy}); end
    end
    reset = 0; #1;
    checks++; if ({cpu_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL rst_release_gnt got %b exp 10", {cpu_gnt, host_gnt}); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rst_release_addr got %h exp 00000100", mem_addr); end
    @(posedge clock); #1;
    idle(1);
  endtask

  task automatic test_cpu_read;
    preload(6'h04, 32'hDEADBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; #1;
    checks++; if ({cpu_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b exp 10", {cpu_gnt, host_gnt}); end
    checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem got %h/%b exp 00000010/0", mem_addr, mem_we); end
    @(posedge clock); #1;
    cpu_req = 0; #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %b/%h exp 1/deadbeef", cpu_rvalid, cpu_rdata); end
    checks++; if (host_rvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_host_busy got %b/%b exp 0/1", host_rvalid, busy); end
    @(posedge clock); #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF || busy !== 1'b0) begin errors++; $display("FAIL rd_after got %b/%h/%b exp 0/deadbeef/0", cpu_rvalid, cpu_rdata, busy); end
  endtask

  task automatic test_fairness;
    cpu_req = 1; host_req = 1; cpu_we = 1; host_we = 1;
    cpu_addr = 32'h80; host_addr = 32'h84;
    for (int i = 0; i < 10; i++) begin
      logic exp_h;
      exp_h = (i % 5 == 4);
      #1;
      checks++; if ({cpu_gnt, host_gnt} !== {~exp_h, exp_h}) begin errors++; $display("FAIL age_cycle%0d got %b exp %b", i, {cpu_gnt, host_gnt}, {~exp_h, exp_h}); end
      @(posedge clock); #1;
    end
    idle(1);
  endtask

  task automatic test_lock_burst;
    int n;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    host_req = 1; host_we = 1; host_lock = 1; host_addr = 32'h30; host_wdata = 32'd1;
    n = 0; #1;
    while (!host_gnt && n < 8) begin @(posedge clock); #2; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL lock_wait got %0d exp 4", n); end
    for (int b = 0; b < 3; b++) begin
      host_addr = 32'h30 + 32'(4 * b); host_wdata = 32'(b + 1); #1;
      checks++; if ({cpu_gnt, host_gnt, mem_we} !== 3'b011 || mem_addr !== host_addr) begin errors++; $display("FAIL lock_beat%0d got %b/%h exp 011/%h", b, {cpu_gnt, host_gnt, mem_we}, mem_addr, host_addr); end
      @(posedge clock); #1;
    end
    host_req = 0; host_lock = 0; #1;
    checks++; if ({cpu_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL lock_release got %b exp 10", {cpu_gnt, host_gnt}); end
    @(posedge clock); #1;
    idle(1);
    checks++; if (mem[12] !== 32'd1 || mem[13] !== 32'd2 || mem[14] !== 32'd3) begin errors++; $display("FAIL lock_mem got %h %h %h exp 1 2 3", mem[12], mem[13], mem[14]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [4];
    d[0] = 32'hA1A1A1A1; d[1] = 32'hB2B2B2B2; d[2] = 32'hC3C3C3C3; d[3] = 32'hD4D4D4D4;
    for (int k = 0; k < 4; k++) preload(6'(16 + k), d[k]);
    cpu_we = 0; host_we = 0; host_lock = 0;
    for (int k = 0; k < 4; k++) begin
      logic exp_cv, exp_hv;
      exp_cv = (k > 0) && ((k - 1) % 2 == 0);
      exp_hv = (k > 0) && ((k - 1) % 2 == 1);
      cpu_req = (k % 2 == 0); host_req = (k % 2 == 1);
      cpu_addr = 32'h40 + 32'(4 * k); host_addr = 32'h40 + 32'(4 * k); #1;
      checks++; if ({cpu_gnt, host_gnt} !== {cpu_req, host_req}) begin errors++; $display("FAIL b2b_gnt%0d got %b exp %b", k, {cpu_gnt, host_gnt}, {cpu_req, host_req}); end
      checks++; if ({cpu_rvalid, host_rvalid} !== {exp_cv, exp_hv}) begin errors++; $display("FAIL b2b_rvalid%0d got %b exp %b", k, {cpu_rvalid, host_rvalid}, {exp_cv, exp_hv}); end
      if (exp_cv) begin checks++; if (cpu_rdata !== d[k-1]) begin errors++; $display("FAIL b2b_cpu_data%0d got %h exp %h", k, cpu_rdata, d[k-1]); end end
      if (exp_hv) begin checks++; if (host_rdata !== d[k-1]) begin errors++; $display("FAIL b2b_host_data%0d got %h exp %h", k, host_rdata, d[k-1]); end end
      @(posedge clock); #1;
    end
    cpu_req = 1; cpu_we = 1; host_req = 0; cpu_addr = 32'h50; cpu_wdata = 32'h55; #1;
    checks++; if ({cpu_gnt, mem_we, host_rvalid, cpu_rvalid} !== 4'b1110) begin errors++; $display("FAIL b2b_wr_inflight got %b exp 1110", {cpu_gnt, mem_we, host_rvalid, cpu_rvalid}); end
    checks++; if (host_rdata !== d[3] || cpu_rdata !== d[2]) begin errors++; $display("FAIL b2b_hold got %h/%h exp %h/%h", host_rdata, cpu_rdata, d[3], d[2]); end
    @(posedge clock); #1;
    cpu_req = 0; #1;
    checks++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin errors++; $display("FAIL b2b_wr_norvalid got %b exp 00", {cpu_rvalid, host_rvalid}); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    host_req = 1; host_we = 0; host_addr = 32'h44; #1;
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", host_gnt); end
    @(posedge clock); #1;
    reset = 1; host_req = 0; #1;
    checks++; if ({host_rvalid, busy} !== 2'b00) begin errors++; $display("FAIL rmid_during got %b exp 00", {host_rvalid, busy}); end
    @(posedge clock); #1;
    reset = 0; #1;
    checks++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin errors++; $display("FAIL rmid_after got %b exp 00", {cpu_rvalid, host_rvalid}); end
    checks++; if (host_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h/%h exp 0/0", host_rdata, cpu_rdata); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if ({cpu_grant_cnt, host_grant_cnt, conflict_cnt} !== 48'h0) begin errors++; $display("FAIL rmid_stats got %h/%h/%h exp 0", cpu_grant_cnt, host_grant_cnt, conflict_cnt); end
`endif
    @(posedge clock); #1;
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_later got %b exp 0", host_rvalid); end
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_fairness;
    test_lock_burst;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sc_dmem_arbiter.md
Name: sc_dmem_arbiter

Overview:
- Two-master arbiter for the single-ported data memory. Requesters are the single-cycle CPU data port and a host/loader port used for debug reads and memory preload.
- Sits between the CPU/host and the data memory.
- Issues at most one access per clock. CPU has default priority; an age counter bounds host starvation. An optional host lock supports bursts.

Parameters:
- ADDR_W, 32, address width for both masters and the memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive cycles a pending host request may be denied before it gets priority (1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  DATA_W  CPU read data.
- host_req  in  1  host access request.
- host_we  in  1  host write enable.
- host_lock  in  1  hold grant across consecutive host requests.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access accepted this cycle (combinational).
- host_rvalid  out  1  host read data valid (registered).
- host_rdata  out  DATA_W  host read data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address.
- busy  out  1  a grant is active or a read is in flight.

Behaviour:
- FSM states: IDLE, CPU_OWN, HOST_OWN, HOST_LOCKED. Reset enters IDLE.
- Grant decision is combinational each cycle, from requests, state and wait_cnt:
  - If state is HOST_LOCKED and host_req=1: host wins regardless of cpu_req.
  - Otherwise, if host_req=1 and wait_cnt==MAX_WAIT: host wins.
  - Otherwise, if cpu_req=1: CPU wins.
  - Otherwise, if host_req=1: host wins.
  - Otherwise: no grant.
- At most one of cpu_gnt/host_gnt is high. Both are 0 while reset=1.
- Memory mux: mem_addr/mem_wdata/mem_we come from the granted master. mem_we=master_we & gnt. With no grant, mem_we=0 and addr/wdata hold the CPU values.
- Next state:
  - CPU grant -> CPU_OWN.
  - Host grant with host_lock=1 -> HOST_LOCKED.
  - Host grant with host_lock=0 -> HOST_OWN.
  - No grant -> IDLE.
  - In HOST_LOCKED with host_req=0: return to IDLE and drop the lock the same cycle, so the CPU may win that cycle.
- wait_cnt (4 bits):
  - Increments when host_req=1 and host not granted, saturating at MAX_WAIT.
  - Clears on host grant or host_req=0.
- Read return, latency 1: a granted read (we=0) sets rd_owner and rd_pend. Next cycle, the owner's rvalid=1 and rdata=mem_rdata.
  - The non-owner's rdata holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads pipeline, one per cycle.
- busy = cpu_gnt | host_gnt | rd_pend.
- Reset values: cpu_gnt=0, host_gnt=0, cpu_rvalid=0, host_rvalid=0, cpu_rdata=0, host_rdata=0, mem_we=0, busy=0, wait_cnt=0, rd_pend=0, state=IDLE.
- Reset mid-operation: an in-flight read is discarded and no rvalid follows.
- Simultaneous requests in IDLE: CPU wins unless the host age limit is reached.
- Request with we=1 and a read in flight: accepted; returned data still goes to the earlier read's owner.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds outputs cpu_grant_cnt[15:0], host_grant_cnt[15:0] and conflict_cnt[15:0].
  - Each increments on its grant, or on cycles where both masters requested; all wrap at 16 bits.
  - Input stats_clr (synchronous) zeroes all three; reset also zeroes them.
- When undefined: these ports and counters do not exist and arbitration is unchanged.

Test Plan:
- Reset held 2 cycles with both reqs=1 -> all grants, rvalids and mem_we=0. After release, CPU wins the first cycle.
- CPU read addr 0x10 with mem holding 0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF next cycle; host_rvalid=0.
- cpu_req and host_req held continuously, MAX_WAIT=4 -> CPU granted 4 cycles, host granted on the 5th, then CPU 4 more; the pattern repeats.
- Host write burst of 3 with host_lock=1 while cpu_req=1 -> host_gnt 3 consecutive cycles and mem_we=1 each. When host_req drops, cpu_gnt=1 the same cycle.
- Alternating CPU read / host read back-to-back -> rvalid goes to the correct master each following cycle with the correct data; no cross-delivery.
- Reset asserted the cycle after a host read grant -> host_rvalid stays 0. With DMEM_ARB_STATS_EN, all counters read 0.
